// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register file widths and the write-request record
package regfile_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NUM_REGS = 8;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: pending-write FIFO with age-ordered entry visibility (slot 0 = oldest)
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  wr_req_t                      din,
  output wr_req_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ent_valid [DEPTH],
  output wr_req_t                      ent       [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PW:0] wptr, rptr;
  wr_req_t mem [DEPTH];
  assign count = wptr - rptr;
  assign full  = count == CW'(DEPTH);
  assign empty = wptr == rptr;
  assign head  = mem[rptr[PW-1:0]];
  // pointer update; flush and reset both empty the queue
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end
  // storage write; push is already gated by flush in the caller
  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= din;
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent[g]       = mem[rptr[PW-1:0] + PW'(g)];
    assign ent_valid[g] = CW'(g) < count;
  end
endmodule

// File: rtl/regfile_wb_driver.sv
// regfile_wb_driver: buffered write-back driver with pending-write forwarding
module regfile_wb_driver
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_data,
  input  logic                       wb_stall,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          wb_addr,
  output logic [DATA_W-1:0]          wb_data,
  output logic                       wb_en,
  input  logic [ADDR_W-1:0]          chk_addr,
  output logic                       chk_hit,
  output logic [DATA_W-1:0]          chk_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  logic push, pop, full, empty;
  wr_req_t head;
  logic ent_valid [DEPTH];
  wr_req_t ent [DEPTH];
  assign req_ready = !full;
  assign push = req_valid && !full && !flush;
  assign pop  = !empty && !wb_stall && !flush;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(flush),
    .din('{addr: req_addr, data: req_data}),
    .head(head),
    .full(full),
    .empty(empty),
    .count(count),
    .ent_valid(ent_valid),
    .ent(ent)
  );
  // issue register: address/data hold when idle, enable drops on stall/flush/empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= pop;
      if (pop) begin
        wb_addr <= head.addr;
        wb_data <= head.data;
      end
    end
  end
  // forwarding: in-flight write is oldest, later FIFO slots override earlier ones
  always_comb begin
    chk_hit  = wb_en && wb_addr == chk_addr;
    chk_data = chk_hit ? wb_data : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent[i].addr == chk_addr) begin
        chk_hit  = 1'b1;
        chk_data = ent[i].data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_driver.sv
// tb_regfile_wb_driver: directed stimulus with a queue-based write-port scoreboard
module tb_regfile_wb_driver;
  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, wb_stall, flush, wb_en, chk_hit;
  logic [2:0] req_addr, wb_addr, chk_addr;
  logic [7:0] req_data, wb_data, chk_data;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q [$];
  always #5 clk = ~clk;
  regfile_wb_driver #(.DATA_W(8), .ADDR_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .wb_stall(wb_stall), .flush(flush),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en), .chk_addr(chk_addr),
    .chk_hit(chk_hit), .chk_data(chk_data), .count(count)
  );
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [2:0] a, input logic [7:0] d, input bit expect_it);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    if (expect_it) exp_q.push_back({a, d});
    tick();
    req_valid = 1'b0;
  endtask
  task automatic monitor();
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", int'(wb_addr), int'(e[10:8]));
          check("wb_data", int'(wb_data), int'(e[7:0]));
        end
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [2:0] ba [4];
    logic [7:0] bd [4];
    int n;
    ba = '{3'd0, 3'd1, 3'd2, 3'd7};
    bd = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    wb_stall = 1'b0; flush = 1'b0; chk_addr = '0;
    fork monitor(); join_none
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_wb_en", int'(wb_en), 0);
    check("rst_wb_addr", int'(wb_addr), 0);
    check("rst_wb_data", int'(wb_data), 0);
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_chk_hit", int'(chk_hit), 0);
    // single write
    send(3'd3, 8'hA5, 1);
    check("single_count", int'(count), 1);
    check("single_en_n", int'(wb_en), 0);
    tick();
    check("single_en_n1", int'(wb_en), 1);
    check("single_addr", int'(wb_addr), 3);
    check("single_data", int'(wb_data), 'hA5);
    check("single_count_n1", int'(count), 0);
    tick();
    check("single_en_n2", int'(wb_en), 0);
    // back-to-back burst
    for (int k = 0; k < 4; k++) begin
      send(ba[k], bd[k], 1);
      check("burst_count", int'(count), 1);
      check("burst_en", int'(wb_en), k > 0 ? 1 : 0);
    end
    tick();
    check("burst_last_en", int'(wb_en), 1);
    check("burst_last_count", int'(count), 0);
    tick();
    check("burst_idle_en", int'(wb_en), 0);
    // stall until full, fifth request held
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) send(3'(k + 4), 8'(8'h80 + k), 1);
    check("full_count", int'(count), 4);
    check("full_ready", int'(req_ready), 0);
    check("full_en", int'(wb_en), 0);
    req_valid = 1'b1; req_addr = 3'd5; req_data = 8'h55;
    exp_q.push_back({3'd5, 8'h55});
    tick(); tick();
    check("held_count", int'(count), 4);
    check("held_ready", int'(req_ready), 0);
    wb_stall = 1'b0;
    tick();
    check("release_count", int'(count), 3);
    check("release_en", int'(wb_en), 1);
    check("release_ready", int'(req_ready), 1);
    tick();
    check("fifth_accept_count", int'(count), 3);
    req_valid = 1'b0;
    n = 0;
    while ((count != 0 || wb_en) && n < 20) begin
      tick();
      n++;
    end
    check("drain_in_bound", int'(n < 20), 1);
    // forwarding
    wb_stall = 1'b1;
    send(3'd2, 8'h10, 1);
    send(3'd2, 8'h20, 1);
    chk_addr = 3'd2; #1;
    check("fwd_hit", int'(chk_hit), 1);
    check("fwd_data_youngest", int'(chk_data), 'h20);
    chk_addr = 3'd4; #1;
    check("fwd_miss_hit", int'(chk_hit), 0);
    check("fwd_miss_data", int'(chk_data), 0);
    chk_addr = 3'd2;
    wb_stall = 1'b0;
    tick();
    check("fwd_inflight_old", int'(chk_data), 'h20);
    tick();
    check("fwd_inflight_hit", int'(chk_hit), 1);
    check("fwd_inflight_data", int'(chk_data), 'h20);
    tick();
    check("fwd_done_hit", int'(chk_hit), 0);
    // flush with concurrent request
    wb_stall = 1'b1;
    send(3'd1, 8'h01, 0);
    send(3'd4, 8'h02, 0);
    send(3'd6, 8'h03, 0);
    check("preflush_count", int'(count), 3);
    flush = 1'b1; req_valid = 1'b1; req_addr = 3'd6; req_data = 8'h77;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_count", int'(count), 0);
    check("flush_en", int'(wb_en), 0);
    check("flush_ready", int'(req_ready), 1);
    wb_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("postflush_en", int'(wb_en), 0);
    end
    // reset mid-burst
    wb_stall = 1'b1;
    send(3'd1, 8'h61, 1);
    send(3'd2, 8'h62, 0);
    send(3'd3, 8'h63, 0);
    wb_stall = 1'b0;
    tick();
    check("prerst_en", int'(wb_en), 1);
    check("prerst_count", int'(count), 2);
    rst_n = 1'b0;
    tick();
    check("midrst_en", int'(wb_en), 0);
    check("midrst_addr", int'(wb_addr), 0);
    check("midrst_data", int'(wb_data), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_ready", int'(req_ready), 1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("postrst_en", int'(wb_en), 0);
    end
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
